// File: rtl/mult_rr_sched.sv
// mult_rr_sched
//   Shares one combinational 16x16 -> 32 unsigned multiplier between NREQ
//   requesters. A round-robin arbiter picks a requester in IDLE. Its operands
//   are captured, the product is registered in MUL, and the response is held
//   in RESP until the owner accepts it. Only one multiply is in flight.
//
//   Optional feature macro: MULT_ZERO_BYPASS_EN
//     When defined, a grant with a zero operand skips MUL. The FSM goes
//     straight to RESP with a zero product.
//
// Parameters
//   NREQ  number of requesters (2..8)
//   IDW   requester id width, clog2(NREQ) (min 1)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req_valid  per-requester operand valid
//   req_x      operand X, requester i at [16*i +: 16]
//   req_y      operand Y, requester i at [16*i +: 16]
//   req_ready  one-hot grant (IDLE only); operands taken when valid & ready
//   rsp_valid  one-hot response valid to the owning requester
//   rsp_p      32-bit product, stable while any rsp_valid is high
//   rsp_id     id of the current response owner
//   rsp_ready  per-requester response accept (only the owner's bit matters)
//   busy       high in any state except IDLE
module mult_rr_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*16-1:0]   req_x,
    input  logic [NREQ*16-1:0]   req_y,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_p,
    output logic [IDW-1:0]       rsp_id,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        RESP
    } state_t;

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  id_r;
    logic [15:0]     x_r;
    logic [15:0]     y_r;
    logic [31:0]     p_r;
    logic [31:0]     prod;

    logic            found;
    logic [IDW-1:0]  win;
    logic [IDW:0]    idx;
    logic [15:0]     win_x;
    logic [15:0]     win_y;

    // Scan from rr_ptr upward with wrap. The first valid requester wins.
    // The index carries one extra bit so that the wrap compare works when
    // NREQ is not a power of two.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NREQ))
                idx = idx - (IDW+1)'(NREQ);
            if (!found && req_valid[idx[IDW-1:0]]) begin
                found = 1'b1;
                win   = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        win_x     = '0;
        win_y     = '0;
        req_ready = '0;
        rsp_valid = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                win_x = req_x[16*i +: 16];
                win_y = req_y[16*i +: 16];
                req_ready[i] = (state == IDLE) && found && !rst;
            end
            if (id_r == IDW'(i))
                rsp_valid[i] = (state == RESP);
        end
    end

    assign prod   = 32'(x_r) * 32'(y_r);
    assign rsp_p  = p_r;
    assign rsp_id = id_r;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            id_r   <= '0;
            x_r    <= '0;
            y_r    <= '0;
            p_r    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        x_r  <= win_x;
                        y_r  <= win_y;
                        id_r <= win;
`ifdef MULT_ZERO_BYPASS_EN
                        if (win_x == '0 || win_y == '0) begin
                            p_r   <= '0;
                            state <= RESP;
                        end else begin
                            state <= MUL;
                        end
`else
                        state <= MUL;
`endif
                    end
                end
                MUL: begin
                    p_r   <= prod;
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_ready[id_r]) begin
                        rr_ptr <= (id_r == IDW'(NREQ-1)) ? '0 : id_r + 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_rr_sched.sv
// Scoreboarded bench for mult_rr_sched (NREQ=4).
module tb_mult_rr_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
`ifdef MULT_ZERO_BYPASS_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 2;
`endif

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*16-1:0] req_x;
    logic [NREQ*16-1:0] req_y;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [31:0]       rsp_p;
    logic [IDW-1:0]    rsp_id;
    logic [NREQ-1:0]   rsp_ready;
    logic              busy;

    mult_rr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_p     (rsp_p),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    typedef struct {
        int          id;
        logic [31:0] p;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   gq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int id, input logic [31:0] p, input int lat);
        exp_t e;
        e.id  = id;
        e.p   = p;
        e.lat = lat;
        sb.push_back(e);
    endtask

    // Monitor: grant timestamps, response latency, and response contents.
    exp_t        em;
    int          g;
    logic [3:0]  prev_v = '0;
    always @(negedge clk) begin
        if (rst) begin
            gq.delete();
            prev_v = '0;
        end else begin
            if (|(req_valid & req_ready))
                gq.push_back(cyc);
            if (rsp_valid != '0 && prev_v == '0) begin
                if (sb.size() == 0 || gq.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    g = gq.pop_front();
                    chk("latency", cyc - g, sb[0].lat);
                end
            end
            if (|(rsp_valid & rsp_ready)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_accept", 32'(rsp_valid), 32'd0);
                end else begin
                    em = sb.pop_front();
                    chk("rsp_id", 32'(rsp_id), em.id);
                    chk("rsp_p", rsp_p, em.p);
                    chk("rsp_valid_onehot", 32'(rsp_valid), 32'd1 << em.id);
                end
            end
            prev_v = rsp_valid;
        end
    end

    task automatic set_req(input int i, input logic [15:0] x, input logic [15:0] y);
        req_x[16*i +: 16] = x;
        req_y[16*i +: 16] = y;
        req_valid[i]      = 1'b1;
    endtask

    // Waits for a grant, checks it is requester i, then drops valid after the edge.
    task automatic wait_grant(input int i, input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == '0 && n < 20);
        chk(name, 32'(req_ready), 32'd1 << i);
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk(name, sb.size(), 0);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k;
        int gi[5];
        int gc[5];
        int ord[5] = '{0, 1, 2, 3, 0};

        rst       = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = '1;
        repeat (2) @(posedge clk);
        #1 req_valid = '1;
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 0);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_rsp_p", rsp_p, 0);
        chk("reset_rsp_id", 32'(rsp_id), 0);
        @(posedge clk);
        #1;
        req_valid = '0;
        rst       = 1'b0;
        @(posedge clk);
        #1;

        // Single request; operands changed after the grant must be ignored.
        set_req(0, 16'h0003, 16'h0005);
        push(0, 32'h0000000F, 2);
        wait_grant(0, "grant_req0", n);
        chk("grant_same_cycle", n, 1);
        req_x[15:0] = 16'hAAAA;
        req_y[15:0] = 16'hBBBB;
        drain("drain_single");

        // Max operands (rr_ptr now 1).
        set_req(2, 16'hFFFF, 16'hFFFF);
        push(2, 32'hFFFE0001, 2);
        wait_grant(2, "grant_req2", n);
        drain("drain_max");

        // Last id accept wraps rr_ptr to 0.
        set_req(3, 16'h0003, 16'h4000);
        push(3, 32'h0000C000, 2);
        wait_grant(3, "grant_req3", n);
        drain("drain_req3");

        // All four valid continuously: order 0,1,2,3,0 at one op per 3 cycles.
        set_req(0, 16'h0002, 16'h0003);
        set_req(1, 16'h0010, 16'h0010);
        set_req(2, 16'h00FF, 16'h0101);
        set_req(3, 16'h8000, 16'h0004);
        push(0, 32'h00000006, 2);
        push(1, 32'h00000100, 2);
        push(2, 32'h0000FFFF, 2);
        push(3, 32'h00020000, 2);
        push(0, 32'h00000006, 2);
        k = 0;
        n = 0;
        while (k < 5 && n < 60) begin
            @(negedge clk);
            n++;
            if (req_ready != '0) begin
                for (int b = 0; b < NREQ; b++)
                    if (req_ready[b]) gi[k] = b;
                gc[k] = cyc;
                k++;
            end
        end
        chk("rr_grant_count", k, 5);
        for (int j = 0; j < k; j++) chk("rr_order", gi[j], ord[j]);
        for (int j = 1; j < k; j++) chk("rr_spacing", gc[j] - gc[j-1], 3);
        @(posedge clk);
        #1 req_valid = '0;
        drain("drain_rr");

        // Backpressure on requester 1; other rsp_ready bits high but ignored.
        rsp_ready = 4'b1101;
        set_req(1, 16'h0007, 16'h0009);
        push(1, 32'h0000003F, 2);
        wait_grant(1, "grant_bp", n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid[1] && n < 10);
        for (int j = 0; j < 5; j++) begin
            if (j > 0) @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'b0010);
            chk("bp_rsp_p", rsp_p, 32'h3F);
            chk("bp_req_ready", 32'(req_ready), 0);
            chk("bp_busy", 32'(busy), 1);
        end
        @(posedge clk);
        #1 rsp_ready = '1;
        drain("drain_bp");

        // Reset during MUL: op dropped, rr_ptr back to 0.
        set_req(3, 16'h1234, 16'h0002);
        wait_grant(3, "grant_pre_reset", n);
        chk("busy_in_mul", 32'(busy), 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("post_reset_rsp_valid", 32'(rsp_valid), 0);
            chk("post_reset_busy", 32'(busy), 0);
        end
        @(posedge clk);
        #1;
        set_req(1, 16'h0011, 16'h0011);
        set_req(2, 16'h0100, 16'h0100);
        push(1, 32'h00000121, 2);
        push(2, 32'h00010000, 2);
        wait_grant(1, "grant_after_reset", n);
        wait_grant(2, "grant_after_reset_2", n);
        drain("drain_after_reset");

        // Zero operands (bypass latency when enabled).
        set_req(0, 16'h0000, 16'hABCD);
        push(0, 32'h0, ZLAT);
        wait_grant(0, "grant_zero_x", n);
        drain("drain_zero_x");
        set_req(1, 16'h1234, 16'h0000);
        push(1, 32'h0, ZLAT);
        wait_grant(1, "grant_zero_y", n);
        drain("drain_zero_y");

        @(negedge clk);
        chk("final_busy", 32'(busy), 0);
        chk("final_rsp_valid", 32'(rsp_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
